// File: rtl/intt_butterfly_if.sv
// rtl/intt_butterfly_if.sv - operand/result handshake bundle for intt_butterfly
interface intt_butterfly_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, a, b, w, q, out_ready,
    input  in_ready, out_valid, x, y
  );

  modport slave (
    input  in_valid, a, b, w, q, out_ready,
    output in_ready, out_valid, x, y
  );
endinterface

// File: rtl/intt_butterfly.sv
// rtl/intt_butterfly.sv - Gentleman-Sande inverse-NTT butterfly, bit-serial modular multiply
// Optional INTT_SCALE_EN halves both results mod q (q must be odd).
module intt_butterfly #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  intt_butterfly_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_step;

  // Sums carry one extra bit so no carry is lost even for q close to 2^WIDTH.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] u,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] u,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    if (u >= v) s = {1'b0, u} - {1'b0, v};
    else        s = {1'b0, u} + {1'b0, m} - {1'b0, v};
    return WIDTH'(s);
  endfunction

`ifdef INTT_SCALE_EN
  // Multiply by 2^-1 mod odd m: odd values become even once m is added.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    if (v[0]) s = {1'b0, v} + {1'b0, m};
    else      s = {1'b0, v};
    return WIDTH'(s >> 1);
  endfunction
`endif

  // One MSB-first double-and-add step; w_q is shifted so its MSB is the current bit.
  always_comb begin
    logic [WIDTH-1:0] t;
    t        = mod_add(acc_q, acc_q, qm_q);
    acc_step = w_q[WIDTH-1] ? mod_add(t, d_q, qm_q) : t;
  end

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    d_d     = d_q;
    qm_d    = qm_q;
    w_d     = w_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          xr_d    = mod_add(bus.a, bus.b, bus.q);
          d_d     = mod_sub(bus.a, bus.b, bus.q);
          qm_d    = bus.q;
          w_d     = bus.w;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_step;
        w_d   = w_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef INTT_SCALE_EN
          x_d = mod_half(xr_q, qm_q);
          y_d = mod_half(acc_step, qm_q);
`else
          x_d = xr_q;
          y_d = acc_step;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      d_q     <= '0;
      qm_q    <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      d_q     <= d_d;
      qm_q    <= qm_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.x         = x_q;
  assign bus.y         = y_q;
endmodule

// File: doc/intt_butterfly.md
INTT_BUTTERFLY -- requirements
Module: intt_butterfly

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand/modulus width and multiplier iteration count.
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand set a/b/w/q valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have ports: a, b, w, q  input  WIDTH each  butterfly inputs, twiddle, modulus.
REQ-007 SHALL have port: out_valid  output  1  x/y valid.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts x/y.
REQ-009 SHALL have ports: x, y  output  WIDTH each  Gentleman-Sande results.

Function
REQ-010 SHALL compute x = (a + b) mod q and y = ((a - b) mod q) * w mod q. This is the inverse-NTT butterfly.
REQ-011 SHALL require 2 <= q and a, b, w < q; outputs are unspecified otherwise.
REQ-012 SHALL implement the FSM states IDLE, MUL and DONE; reset state IDLE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; the block holds one operation at a time.
REQ-014 SHALL, on an edge in IDLE with in_valid=1, perform all of the following:
- register xr = (a+b) mod q and d = (a-b) mod q (if a>=b then a-b, else a+q-b);
- register q and w, clear acc and the counter;
- enter MUL.
REQ-015 SHALL use WIDTH+1-bit intermediates for every sum, so that no carry is lost for any q < 2^WIDTH.
REQ-016 SHALL perform one MSB-first double-and-add step per MUL edge:
- t = 2*acc mod q;
- acc = t + d mod q if the current w bit is 1, else acc = t;
- consume w bits from WIDTH-1 down to 0.
REQ-017 SHALL, on the edge that performs iteration WIDTH-1, load x and y and enter DONE. out_valid therefore rises exactly WIDTH edges after the accepting edge (64 for the default).
REQ-018 SHALL hold out_valid=1 with x and y stable in DONE until an edge with out_ready=1, then return to IDLE. in_ready=1 from the following cycle.
REQ-019 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-020 SHALL produce intermediate values where each reduction is a single conditional subtract of q, and the value stays < q after every step.

Reset
REQ-021 SHALL, on an edge with rst=1, regardless of state, perform all of the following:
- set state IDLE;
- set out_valid=0, in_ready=1 (combinational from IDLE);
- set x=0, y=0, acc=0 and the counter to 0.
REQ-022 SHALL discard any in-flight operation on reset mid-MUL or mid-DONE, with no output produced.
REQ-023 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-024 SHALL, with INTT_SCALE_EN defined, load x = xr*2^-1 mod q and y = acc*2^-1 mod q at the REQ-017 edge:
- halving rule: v even -> v>>1, v odd -> (v+q)>>1, computed in WIDTH+1 bits;
- q is required odd;
- latency is unchanged.
REQ-025 SHALL, without INTT_SCALE_EN, output the unscaled x and y, with no halving logic present.

Verification
REQ-026 SHALL cover: q=17, a=5, b=3, w=4, out_ready=1 -> x=8, y=8; out_valid exactly 64 edges after accept; in_ready=1 the cycle after the handshake.
REQ-027 SHALL cover: q=17, a=3, b=5, w=4 (borrow path) -> x=8, y=9; with INTT_SCALE_EN -> x=4, y=13.
REQ-028 SHALL cover: q=0xFFFFFFFFFFFFFFC5, a=q-1, b=0, w=q-1 -> x=q-1, y=1; a=q-1, b=q-1, w=q-1 -> x=q-2, y=0 (carry-width check).
REQ-029 SHALL cover: q=17, a=16, b=16, w=16, out_ready held 0 for 10 cycles after out_valid -> x=15, y=0 stable and out_valid=1 throughout, in_ready=0; release -> one handshake, then IDLE.
REQ-030 SHALL cover: rst=1 asserted at MUL iteration 30 -> next cycle out_valid=0, in_ready=1, x=y=0; a new op q=17, a=1, b=0, w=1 -> x=1, y=1 after 64 edges.
REQ-031 SHALL cover: in_valid held 1 with changing a/b during MUL and DONE -> no effect on the result; exactly one op per handshake.
